mult_div_engine: RTL and testbench

- Sequential signed multiply/divide responder for the multicycle MIPS datapath.
- The control FSM (initiator) pulses `start` with `op` and operands taken from the register-file A/B outputs.
- The engine iterates, then returns a 64-bit result split into `hi_out`/`lo_out` with a one-cycle `done` pulse.
- The datapath loads `hi_out`/`lo_out` into its HI/LO registers on `done`, and raises the divide-by-zero exception from `div_by_zero`.

---
 rtl/mult_div_engine.sv | 154 +++++++++++++++
 tb/tb_mult_div_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_engine.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes) engine.
// Results go to hi_out/lo_out, qualified by a one-cycle done pulse.
module mult_div_engine #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   acc;      // MULT: {P_hi, P_lo, q-1}; DIV: {rem, quo, spare}
    logic [WIDTH-1:0]   opnd;     // MULT: multiplicand; DIV: |divisor|
    logic               sign_a;
    logic               sign_b;
    logic               dz_wait;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH:0]   booth_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH:0]   div_next;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    assign rem = acc[2*WIDTH:WIDTH+1];
    assign quo = acc[WIDTH:1];

    // Booth step: sign-extended add/sub keeps -2^31 multiplicands exact, then shift.
    always_comb begin
        booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = booth_sum + {opnd[WIDTH-1], opnd};
            2'b10:   booth_sum = booth_sum - {opnd[WIDTH-1], opnd};
            default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        endcase
        booth_next = {booth_sum, acc[WIDTH:1]};
    end

    // Restoring division step: one quotient bit per cycle.
    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1, 1'b0};
        end else begin
            div_next = {div_shift[WIDTH-1:0], quo[WIDTH-2:0], 1'b0, 1'b0};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A divide-by-zero lingers one extra cycle in DONE so its pulse lands one cycle later.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!op)                state_next = S_MULT;
                    else if (b_in == '0)    state_next = S_DONE;
                    else                    state_next = S_DIV;
                end
            end
            S_MULT:  if (cnt == LAST) state_next = S_DONE;
            S_DIV:   if (cnt == LAST) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = dz_wait ? S_DONE : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dz_wait     <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state_next == S_DONE) && (state != S_IDLE);
            busy <= state_next inside {S_MULT, S_DIV, S_FIX};
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        sign_a      <= a_in[WIDTH-1];
                        sign_b      <= b_in[WIDTH-1];
                        div_by_zero <= 1'b0;
                        if (!op) begin
                            acc  <= {{WIDTH{1'b0}}, b_in, 1'b0};
                            opnd <= a_in;
                        end else if (b_in == '0) begin
                            div_by_zero <= 1'b1;
                            dz_wait     <= 1'b1;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag(a_in), 1'b0};
                            opnd <= mag(b_in);
                        end
                    end
                end
                S_MULT: begin
                    if (cnt == LAST) begin
                        hi_out <= acc[2*WIDTH:WIDTH+1];
                        lo_out <= acc[WIDTH:1];
                    end else begin
                        acc <= booth_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DIV: begin
                    if (cnt != LAST) begin
                        acc <= div_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    hi_out <= sign_a ? WIDTH'(-rem) : rem;
                    lo_out <= (sign_a ^ sign_b) ? WIDTH'(-quo) : quo;
                end
                S_DONE:  dz_wait <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_engine.sv
// Directed bench for mult_div_engine: latency, busy/done framing, signed results, reset abort.
module tb_mult_div_engine;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    int          r_lat, r_bn, r_bf;
    logic        r_dz1, r_da, r_dz;
    logic [31:0] r_hi, r_lo;

    mult_div_engine #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
        .done(done), .busy(busy), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    // Called at a falling edge with the engine idle; returns at the falling edge after done.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bn, output int bf, output logic dz1,
                          output logic da, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz);
        lat = 0; bn = 0; bf = 0; dz1 = 1'bx; da = 1'bx; hi = 'x; lo = 'x; dz = 1'bx;
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clock);
        #1;
        start = 1'b0; a_in = ~a ^ 32'h5A5A_A5A5; b_in = 32'h0000_0000;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (busy === 1'b1) begin
                bn++;
                if (bf == 0) bf = k;
            end
            if (k == 1) dz1 = div_by_zero;
            if (lat != 0) begin
                da = done;
                break;
            end
            if (done === 1'b1) begin
                lat = k; hi = hi_out; lo = lo_out; dz = div_by_zero;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        #2;
        total++;
        if ({hi_out, lo_out, done, busy, div_by_zero} !== 67'd0) begin
            bad++; $display("FAIL reset_state got hi=%h lo=%h d=%b b=%b z=%b want all 0",
                            hi_out, lo_out, done, busy, div_by_zero);
        end
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mult();
        run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if (r_lat !== 34) begin bad++; $display("FAIL mult_latency got %0d want 34", r_lat); end
        total++;
        if (r_bn !== 33 || r_bf !== 1) begin
            bad++; $display("FAIL mult_busy got count=%0d first=%0d want 33/1", r_bn, r_bf);
        end
        total++;
        if (r_da !== 1'b0) begin bad++; $display("FAIL mult_done_width got %b want 0", r_da); end
        total++;
        if ({r_hi, r_lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            bad++; $display("FAIL mult_7x-3 got %h_%h want ffffffff_ffffffeb", r_hi, r_lo);
        end
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if ({r_hi, r_lo} !== 64'h4000_0000_0000_0000) begin
            bad++; $display("FAIL mult_min_sq got %h_%h want 40000000_00000000", r_hi, r_lo);
        end
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if ({r_hi, r_lo} !== 64'h0000_0000_0000_0001) begin
            bad++; $display("FAIL mult_neg1_sq got %h_%h want 00000000_00000001", r_hi, r_lo);
        end
    endtask

    task automatic test_div();
        run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if (r_lat !== 35 || r_bn !== 34) begin
            bad++; $display("FAIL div_timing got lat=%0d busy=%0d want 35/34", r_lat, r_bn);
        end
        total++;
        if ({r_hi, r_lo, r_dz} !== {32'h0000_0001, 32'hFFFF_FFFD, 1'b0}) begin
            bad++; $display("FAIL div_7/-2 got r=%h q=%h z=%b want 00000001 fffffffd 0", r_hi, r_lo, r_dz);
        end
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if ({r_hi, r_lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            bad++; $display("FAIL div_-7/2 got r=%h q=%h want ffffffff fffffffd", r_hi, r_lo);
        end
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if ({r_hi, r_lo, r_dz} !== {32'h0000_0000, 32'h8000_0000, 1'b0}) begin
            bad++; $display("FAIL div_min/-1 got r=%h q=%h z=%b want 00000000 80000000 0", r_hi, r_lo, r_dz);
        end
    endtask

    task automatic test_div_by_zero();
        run_op(1'b1, 32'h0000_0005, 32'h0000_0000, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if (r_lat !== 2 || r_bn !== 0 || r_da !== 1'b0) begin
            bad++; $display("FAIL dz_timing got lat=%0d busy=%0d after=%b want 2/0/0", r_lat, r_bn, r_da);
        end
        total++;
        if ({r_hi, r_lo, r_dz} !== {32'h0000_0000, 32'h8000_0000, 1'b1}) begin
            bad++; $display("FAIL dz_result got hi=%h lo=%h z=%b want 00000000 80000000 1", r_hi, r_lo, r_dz);
        end
        total++;
        if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_hold got %b want 1", div_by_zero); end
        run_op(1'b0, 32'h0000_0002, 32'h0000_0003, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if (r_dz1 !== 1'b0 || r_lo !== 32'd6 || r_hi !== 32'd0) begin
            bad++; $display("FAIL dz_clear got z1=%b hi=%h lo=%h want 0 0 6", r_dz1, r_hi, r_lo);
        end
    endtask

    task automatic test_reset_abort();
        int dn;
        dn = 0;
        start = 1'b1; op = 1'b0; a_in = 32'd9; b_in = 32'd9;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({hi_out, lo_out, done, busy, div_by_zero} !== 67'd0) begin
            bad++; $display("FAIL abort_clear got hi=%h lo=%h d=%b b=%b z=%b want all 0",
                            hi_out, lo_out, done, busy, div_by_zero);
        end
        repeat (3) begin
            @(negedge clock);
            if (done === 1'b1) dn++;
        end
        reset = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done !== 1'b0) dn++;
        end
        total++;
        if (dn !== 0) begin bad++; $display("FAIL abort_no_done got %0d pulses want 0", dn); end
        run_op(1'b0, 32'd3, 32'd4, r_lat, r_bn, r_bf, r_dz1, r_da, r_hi, r_lo, r_dz);
        total++;
        if (r_lat !== 34 || {r_hi, r_lo} !== 64'd12) begin
            bad++; $display("FAIL abort_then_mult got lat=%0d %h_%h want 34 0_c", r_lat, r_hi, r_lo);
        end
    endtask

    task automatic test_back_to_back();
        int          d1, d2, extra;
        logic [63:0] v1, v2;
        d1 = 0; d2 = 0; extra = 0; v1 = 'x; v2 = 'x;
        start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd6;
        for (int n = 1; n <= 72; n++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (d1 == 0) begin d1 = n; v1 = {hi_out, lo_out}; end
                else if (d2 == 0) begin d2 = n; v2 = {hi_out, lo_out}; end
                else extra++;
            end
            if (n == 35) begin
                a_in = 32'hFFFF_FFF7; b_in = 32'd11;
            end else begin
                a_in = 32'(n) * 32'h9E37_79B9; b_in = ~a_in;
            end
        end
        start = 1'b0;
        total++;
        if (d1 !== 34 || v1 !== 64'd30) begin
            bad++; $display("FAIL b2b_first got at=%0d val=%h want 34 1e", d1, v1);
        end
        total++;
        if (d2 !== 69 || v2 !== 64'hFFFF_FFFF_FFFF_FF9D || extra !== 0) begin
            bad++; $display("FAIL b2b_second got at=%0d val=%h extra=%0d want 69 ffffffffffffff9d 0",
                            d2, v2, extra);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
